// File: rtl/manchester_tx_scheduler_pkg.sv
// rtl/manchester_tx_scheduler_pkg.sv - shared states and framing constants for the Manchester frame scheduler
package manchester_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SOF   = 3'd2,
    ST_HDR   = 3'd3,
    ST_PAY   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_GAP   = 3'd6
  } sched_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] DEFAULT_SFD   = 8'hD5;
  localparam int         HDR_ID_W      = 2;
  localparam int         HDR_PAD_W     = 8 - HDR_ID_W;

endpackage

// File: rtl/manchester_tx_scheduler_rr_arbiter.sv
// rtl/manchester_tx_scheduler_rr_arbiter.sv - round-robin requester picker with a last-grant pointer
module manchester_tx_scheduler_rr_arbiter
  import manchester_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  output logic             grant_valid,
  output logic [1:0]       grant_idx
);

  logic [1:0] ptr_q;
  logic [3:0] req_pad;
  logic [2:0] cand;

  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr_q <= 2'(N_REQ - 1);
    end else if (update && grant_valid) begin
      ptr_q <= grant_idx;
    end
  end

  // Walk farthest-first so the nearest requester after the pointer wins.
  always_comb begin
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = req;
    grant_valid          = 1'b0;
    grant_idx            = '0;
    cand                 = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (req_pad[cand[1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/manchester_tx_scheduler.sv
// rtl/manchester_tx_scheduler.sv - frames requester payloads for the Manchester sender and enforces the gap
module manchester_tx_scheduler
  import manchester_tx_scheduler_pkg::*;
#(
  parameter int         N_REQ        = 2,
  parameter int         PREAMBLE_LEN = 4,
  parameter logic [7:0] SFD          = DEFAULT_SFD,
  parameter int         MAX_LEN      = 64,
  parameter int         IFG_CYCLES   = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [8*N_REQ-1:0] s_tdata,
  input  logic [N_REQ-1:0]   s_tvalid,
  input  logic [N_REQ-1:0]   s_tlast,
  output logic [N_REQ-1:0]   s_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic               busy,
  output logic [1:0]         grant_id,
  output logic               trunc_err
);

  sched_state_t     state_q, state_d;
  logic [1:0]       grant_q;
  logic [7:0]       cnt_q, tx_data_q;
  logic             tx_valid_q, trunc_q;
  logic             arb_valid, arb_update;
  logic [1:0]       arb_idx;
  logic [7:0]       sel_data;
  logic             sel_valid, sel_last;
  logic             hdr_hs, pay_hs, at_max, cnt_en, trunc_set;
  logic [7:0]       m_tdata_c;
  logic             m_tvalid_c, m_tlast_c;
  logic [N_REQ-1:0] s_tready_c;

  manchester_tx_scheduler_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .aclk        (aclk),
    .areset      (areset),
    .req         (s_tvalid),
    .update      (arb_update),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        sel_data  = s_tdata[8*i +: 8];
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
      end
    end
  end

  assign hdr_hs = tx_valid_q & m_tready;
  assign pay_hs = sel_valid & m_tready;
  assign at_max = (cnt_q == 8'(MAX_LEN - 1));

  always_comb begin
    state_d    = state_q;
    arb_update = 1'b0;
    m_tdata_c  = '0;
    m_tvalid_c = 1'b0;
    m_tlast_c  = 1'b0;
    s_tready_c = '0;
    cnt_en     = 1'b0;
    trunc_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          state_d    = ST_PRE;
        end
      end
      ST_PRE: begin
        m_tdata_c  = tx_data_q;
        m_tvalid_c = tx_valid_q;
        cnt_en     = hdr_hs;
        if (hdr_hs && cnt_q == 8'(PREAMBLE_LEN - 1)) state_d = ST_SOF;
      end
      ST_SOF: begin
        m_tdata_c  = tx_data_q;
        m_tvalid_c = tx_valid_q;
        if (hdr_hs) state_d = ST_HDR;
      end
      ST_HDR: begin
        m_tdata_c  = tx_data_q;
        m_tvalid_c = tx_valid_q;
        if (hdr_hs) state_d = ST_PAY;
      end
      ST_PAY: begin
        m_tdata_c  = sel_data;
        m_tvalid_c = sel_valid;
        m_tlast_c  = sel_last | at_max;
        cnt_en     = pay_hs;
        for (int i = 0; i < N_REQ; i++) s_tready_c[i] = (grant_q == 2'(i)) & m_tready;
        if (pay_hs) begin
          if (sel_last) begin
            state_d = ST_GAP;
          end else if (at_max) begin
            state_d   = ST_DRAIN;
            trunc_set = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        for (int i = 0; i < N_REQ; i++) s_tready_c[i] = (grant_q == 2'(i));
        if (sel_valid && sel_last) state_d = ST_GAP;
      end
      ST_GAP: begin
        cnt_en = 1'b1;
        if (cnt_q == 8'(IFG_CYCLES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One counter serves preamble, payload and gap; it restarts on every state change.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      trunc_q <= trunc_set;
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_en)        cnt_q <= cnt_q + 8'd1;
      if (arb_update) begin
        grant_q    <= arb_idx;
        tx_data_q  <= PREAMBLE_BYTE;
        tx_valid_q <= 1'b1;
      end else if (hdr_hs) begin
        case (state_q)
          ST_PRE:  if (state_d == ST_SOF) tx_data_q <= SFD;
          ST_SOF:  tx_data_q <= {{HDR_PAD_W{1'b0}}, grant_q};
          ST_HDR:  tx_valid_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Reset masks the handshakes so an aborted frame neither emits nor consumes a byte.
  assign m_tdata   = m_tdata_c;
  assign m_tvalid  = m_tvalid_c & ~areset;
  assign m_tlast   = m_tlast_c & ~areset;
  assign s_tready  = s_tready_c & {N_REQ{~areset}};
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;
  assign trunc_err = trunc_q;

endmodule

// File: tb/tb_manchester_tx_scheduler.sv
// tb/tb_manchester_tx_scheduler.sv - directed bench for the Manchester frame scheduler
module tb_manchester_tx_scheduler;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid, s_tlast, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready, busy, trunc_err;
  logic [1:0]  grant_id;

  always #5 aclk = ~aclk;

  manchester_tx_scheduler dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .busy      (busy),
    .grant_id  (grant_id),
    .trunc_err (trunc_err)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] rq0[$], rq1[$], out_q[$], exp_q[$];
  logic acc0, acc1, busy_s, gap_run, prev_stall, toggle_mode;
  logic [7:0] prev_data;
  int trunc_cnt, drain_acc, stall_viol, stall_cnt, gap_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req();
    logic [8:0] h0, h1;
    h0 = (rq0.size() > 0) ? rq0[0] : 9'h0;
    h1 = (rq1.size() > 0) ? rq1[0] : 9'h0;
    s_tvalid = {rq1.size() > 0, rq0.size() > 0};
    s_tlast  = {h1[8], h0[8]};
    s_tdata  = {h1[7:0], h0[7:0]};
  endtask

  task automatic step();
    @(negedge aclk);
    busy_s = busy;
    acc0   = s_tvalid[0] & s_tready[0];
    acc1   = s_tvalid[1] & s_tready[1];
    if (gap_run) begin
      if (busy) gap_len++;
      else      gap_run = 1'b0;
    end
    if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) stall_viol++;
    prev_stall = m_tvalid & ~m_tready;
    prev_data  = m_tdata;
    if (prev_stall) stall_cnt++;
    if (m_tvalid && m_tready) begin
      out_q.push_back({m_tlast, m_tdata});
      if (m_tlast) begin
        gap_run = 1'b1;
        gap_len = 0;
      end
    end
    if (trunc_err) trunc_cnt++;
    if ((|(s_tvalid & s_tready)) && !m_tvalid) drain_acc++;
    @(posedge aclk);
    #1;
    if (acc0) void'(rq0.pop_front());
    if (acc1) void'(rq1.pop_front());
    drive_req();
    m_tready = toggle_mode ? ~m_tready : 1'b1;
  endtask

  task automatic clear_mon();
    trunc_cnt = 0; drain_acc = 0; stall_viol = 0; stall_cnt = 0;
    gap_len = 0; gap_run = 1'b0; prev_stall = 1'b0;
    out_q.delete(); exp_q.delete();
  endtask

  task automatic load_req(input int r, input int n, input int first, input int stp);
    for (int i = 0; i < n; i++) begin
      if (r == 0) rq0.push_back({i == n - 1, 8'(first + i * stp)});
      else        rq1.push_back({i == n - 1, 8'(first + i * stp)});
    end
    drive_req();
  endtask

  task automatic add_exp(input int id, input int n, input int first, input int stp, input int lim);
    int m;
    m = (n < lim) ? n : lim;
    for (int i = 0; i < 4; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    exp_q.push_back(9'(id));
    for (int i = 0; i < m; i++) exp_q.push_back({i == m - 1, 8'(first + i * stp)});
  endtask

  task automatic run_idle(input string tag, input int maxc);
    int  c;
    logic done;
    c = 0;
    done = 1'b0;
    while (!done && c < maxc) begin
      step();
      c++;
      done = !busy_s && rq0.size() == 0 && rq1.size() == 0;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic cmp_out(input string tag);
    check({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    step();
    areset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    areset = 1'b1; m_tready = 1'b1; toggle_mode = 1'b0; busy_s = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    clear_mon();
    repeat (3) step();
    areset = 1'b0;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_trunc", 32'(trunc_err), 32'd0);

    // basic 3-byte frame
    clear_mon();
    load_req(0, 3, 'h11, 'h11);
    add_exp(0, 3, 'h11, 'h11, 64);
    run_idle("t1", 200);
    cmp_out("t1");
    check("t1_gap", gap_len, 16);
    check("t1_trunc", trunc_cnt, 0);

    // simultaneous requesters right after reset, round robin
    pulse_reset();
    clear_mon();
    load_req(0, 2, 'h41, 1);
    load_req(0, 2, 'h51, 1);
    load_req(1, 3, 'h81, 1);
    add_exp(0, 2, 'h41, 1, 64);
    add_exp(1, 3, 'h81, 1, 64);
    add_exp(0, 2, 'h51, 1, 64);
    run_idle("t2", 400);
    cmp_out("t2");

    // m_tready toggling
    clear_mon();
    toggle_mode = 1'b1;
    load_req(0, 5, 'h31, 1);
    add_exp(0, 5, 'h31, 1, 64);
    run_idle("t3", 400);
    toggle_mode = 1'b0;
    cmp_out("t3");
    check("t3_stable", stall_viol, 0);
    check("t3_stalls_seen", 32'(stall_cnt > 0), 32'd1);

    // truncation at MAX_LEN with drain
    clear_mon();
    load_req(1, 67, 1, 1);
    add_exp(1, 67, 1, 1, 64);
    run_idle("t4", 600);
    cmp_out("t4");
    check("t4_trunc", trunc_cnt, 1);
    check("t4_drain", drain_acc, 3);

    // single-byte frame
    clear_mon();
    load_req(0, 1, 'hA5, 0);
    add_exp(0, 1, 'hA5, 0, 64);
    run_idle("t5", 200);
    cmp_out("t5");
    check("t5_trunc", trunc_cnt, 0);

    // reset while byte 2 of the payload is on the bus
    clear_mon();
    load_req(0, 5, 'h61, 1);
    c = 0;
    while (out_q.size() < 7 && c < 100) begin
      step();
      c++;
    end
    check("t6_reach_pay", 32'(out_q.size() >= 7), 32'd1);
    load_req(1, 1, 'h77, 0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    check("t6_m_tvalid", 32'(m_tvalid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_grant", 32'(grant_id), 32'd0);
    check("t6_kept", rq0.size(), 4);
    out_q.delete();
    add_exp(0, 4, 'h62, 1, 64);
    add_exp(1, 1, 'h77, 0, 64);
    run_idle("t6", 400);
    cmp_out("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
